// File: rtl/quad_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// quad_seg_scan_ctrl
//   Scan scheduler for a 4-digit seven-segment display. Each digit gets a slot
//   of BLANK_CYC cycles with all anodes off, followed by DWELL_CYC cycles lit.
//   Digits are scanned in the fixed order 0,1,2,3. Displayed values come from
//   shadow registers that are only reloaded at a frame boundary, or while the
//   scan is idle, through a req/ack handshake, so a frame never mixes old and
//   new values. Leading zeros can be blanked, and the lz_en control is live.
//
// Optional feature (macro QUAD_SEG_PWM_EN):
//   Adds i_brightness. In SHOW the anode is on only while cnt[3:0] <= brightness.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_enable       1 = scan running, 0 = display dark
//   i_nums[15:0]   {num3,num2,num1,num0}, captured on the handshake only
//   i_dp_mask[3:0] dot enable per digit, captured together with i_nums
//   i_lz_en        leading-zero suppression enable (live)
//   i_upd_req      level request to load i_nums / i_dp_mask
//   i_brightness   PWM level 0..15 (QUAD_SEG_PWM_EN builds only)
//   o_upd_ack      1-cycle pulse: shadow registers hold the new values this cycle
//   o_hex[3:0]     nibble of the selected digit, feeds the hex decoder
//   o_an[3:0]      anodes, active-low
//   o_dp_n         decimal point, active-low
//   o_frame_sync   1-cycle pulse in the first BLANK cycle of digit 0
// ---------------------------------------------------------------------------
module quad_seg_scan_ctrl #(
    parameter int DWELL_CYC = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic [15:0] i_nums,
    input  logic [3:0]  i_dp_mask,
    input  logic        i_lz_en,
    input  logic        i_upd_req,
`ifdef QUAD_SEG_PWM_EN
    input  logic [3:0]  i_brightness,
`endif
    output logic        o_upd_ack,
    output logic [3:0]  o_hex,
    output logic [3:0]  o_an,
    output logic        o_dp_n,
    output logic        o_frame_sync
);

    localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    // At least 4 bits so the PWM comparison on cnt[3:0] is always legal.
    localparam int CNT_W   = ($clog2(CNT_MAX) < 4) ? 4 : $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [1:0]         r_idx, w_idx_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [15:0]        r_nums, w_nums_next;
    logic [3:0]         r_dp, w_dp_next;
    logic               w_load;
    logic               w_frame_start;
    logic [3:0]         w_supp;
    logic [3:0]         w_an_next;
    logic               w_dp_n_next;
    logic [3:0]         w_hex_next;
    logic               w_lit;

    logic               r_upd_ack;
    logic [3:0]         r_hex;
    logic [3:0]         r_an;
    logic               r_dp_n;
    logic               r_frame_sync;

    // Next-state logic. The disable override sits last so it wins from any
    // state, but it does not cancel a frame-end load decided in SHOW.
    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_cnt_next    = r_cnt;
        w_load        = 1'b0;
        w_frame_start = 1'b0;
        case (r_state)
            IDLE: begin
                // A request held through an ack must not reload every cycle.
                w_load = i_upd_req && !r_upd_ack;
                if (i_enable) begin
                    w_state_next  = BLANK;
                    w_idx_next    = 2'd0;
                    w_cnt_next    = '0;
                    w_frame_start = 1'b1;
                end
            end
            BLANK: begin
                if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
                    w_state_next = SHOW;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            SHOW: begin
                if (r_cnt == CNT_W'(DWELL_CYC - 1)) begin
                    w_state_next = BLANK;
                    w_cnt_next   = '0;
                    w_idx_next   = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_load        = i_upd_req;
                        w_frame_start = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (!i_enable) begin
            w_state_next  = IDLE;
            w_idx_next    = 2'd0;
            w_cnt_next    = '0;
            w_frame_start = 1'b0;
        end
    end

    assign w_nums_next = w_load ? i_nums    : r_nums;
    assign w_dp_next   = w_load ? i_dp_mask : r_dp;

    // Digit gi is suppressed when it and every higher digit are zero.
    assign w_supp[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_supp
            assign w_supp[gi] = i_lz_en && (w_nums_next[15:4*gi] == '0);
        end
    endgenerate

`ifdef QUAD_SEG_PWM_EN
    assign w_lit = !w_supp[w_idx_next] && (w_cnt_next[3:0] <= i_brightness);
`else
    assign w_lit = !w_supp[w_idx_next];
`endif

    // Outputs are registered from the next state so they line up with the
    // state register. hex is presented from BLANK onward so the decoder has
    // settled before the anode turns on.
    always_comb begin
        w_an_next   = 4'hF;
        w_dp_n_next = 1'b1;
        w_hex_next  = r_hex;
        if (w_state_next != IDLE) begin
            w_hex_next = w_nums_next[{w_idx_next, 2'b00} +: 4];
        end
        if (w_state_next == SHOW && w_lit) begin
            w_an_next[w_idx_next] = 1'b0;
            w_dp_n_next           = ~w_dp_next[w_idx_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= 2'd0;
            r_cnt        <= '0;
            r_nums       <= 16'h0000;
            r_dp         <= 4'h0;
            r_upd_ack    <= 1'b0;
            r_hex        <= 4'h0;
            r_an         <= 4'hF;
            r_dp_n       <= 1'b1;
            r_frame_sync <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_cnt        <= w_cnt_next;
            r_nums       <= w_nums_next;
            r_dp         <= w_dp_next;
            r_upd_ack    <= w_load;
            r_hex        <= w_hex_next;
            r_an         <= w_an_next;
            r_dp_n       <= w_dp_n_next;
            r_frame_sync <= w_frame_start;
        end
    end

    assign o_upd_ack    = r_upd_ack;
    assign o_hex        = r_hex;
    assign o_an         = r_an;
    assign o_dp_n       = r_dp_n;
    assign o_frame_sync = r_frame_sync;

endmodule
